ram_access_ctrl: RTL and testbench

//  Sequences a single-port 32x4 RAM shared by two requesters: user writes (switch address/data,
//  KEY strobe) and an auto-scan reader that steps through every address on a timer tick.

---
 rtl/ram_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_ram_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - shared single-port RAM sequencer for user writes and timed scan reads
module ram_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              wr_done,
  output logic              busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WRITE    = 2'd1;
  localparam logic [1:0] RD_ISSUE = 2'd2;
  localparam logic [1:0] RD_WAIT  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              prev;
  logic              wr_pend;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              scan_pend;
  logic              refresh;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              tick;
  logic              wr_edge;
  logic              wr_accept;
  logic              wr_hit;
  logic [ADDR_W-1:0] issue_addr;

  assign tick       = (cnt == CNT_MAX);
  assign wr_edge    = wr_req & ~prev;
  // A new edge is ignored while one write is queued or being performed.
  assign wr_accept  = wr_edge & ~wr_pend & (state != WRITE);
  assign wr_hit     = (state == WRITE) && (wa_q == scan_addr);
  // Refresh re-reads the shown address; otherwise step to the next one (wraps naturally).
  assign issue_addr = refresh ? scan_addr : scan_addr + ADDR_W'(1);
  assign busy       = (state != IDLE) | wr_pend | scan_pend;

  // Free-running scan timer, wraps after TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Rising-edge detect on wr_req and capture of the write request.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b1;
      wr_pend <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      prev <= wr_req;
      if (wr_accept) begin
        wr_pend <= 1'b1;
        wa_q    <= wr_addr;
        wd_q    <= wr_data;
      end else if (state == WRITE) begin
        wr_pend <= 1'b0;
      end
    end
  end

  // Scan request bookkeeping: a tick always wins over a refresh request on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_pend <= 1'b1;
      refresh   <= 1'b1;
    end else begin
      if (state == RD_ISSUE) scan_pend <= 1'b0;
      if (state == RD_WAIT)  refresh   <= 1'b0;
      if (wr_hit) begin
        scan_pend <= 1'b1;
        refresh   <= 1'b1;
      end
      if (tick) begin
        scan_pend <= 1'b1;
        refresh   <= 1'b0;
      end
    end
  end

  // Access sequencer: writes take priority over scan reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_pend)        state <= WRITE;
          else if (scan_pend) state <= RD_ISSUE;
        end
        WRITE:    state <= IDLE;
        RD_ISSUE: state <= RD_WAIT;
        default:  state <= IDLE;
      endcase
    end
  end

  // Scan result registers and write-completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q  <= '0;
      scan_addr  <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
      wr_done    <= 1'b0;
    end else begin
      wr_done <= (state == WRITE);
      if (state == RD_ISSUE) rd_addr_q <= issue_addr;
      if (state == RD_WAIT) begin
        scan_data  <= ram_dout;
        scan_addr  <= rd_addr_q;
        scan_valid <= 1'b1;
      end
    end
  end

  // RAM port decode from the current state.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      WRITE: begin
        ram_we   = 1'b1;
        ram_addr = wa_q;
        ram_din  = wd_q;
      end
      RD_ISSUE: ram_addr = issue_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] ram_addr;
  logic [3:0] ram_din;
  logic       ram_we;
  logic [3:0] ram_dout;
  logic [4:0] scan_addr;
  logic [3:0] scan_data;
  logic       scan_valid;
  logic       wr_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  logic [3:0] mem [0:31] = '{
    4'h3, 4'hA, 4'h1, 4'h8, 4'hF, 4'h6, 4'hD, 4'h4,
    4'hB, 4'h2, 4'h9, 4'h0, 4'h7, 4'hE, 4'h5, 4'hC,
    4'h3, 4'hA, 4'h1, 4'h8, 4'hF, 4'h6, 4'hD, 4'h4,
    4'hB, 4'h2, 4'h9, 4'h0, 4'h7, 4'hE, 4'h5, 4'hC};

  logic [3:0] exp_mem [0:31] = '{
    4'h3, 4'hA, 4'h1, 4'h8, 4'hF, 4'h6, 4'hD, 4'h4,
    4'hB, 4'h2, 4'h9, 4'h0, 4'h7, 4'hE, 4'h5, 4'hC,
    4'h3, 4'hA, 4'h1, 4'h8, 4'hF, 4'h6, 4'hD, 4'h4,
    4'hB, 4'h2, 4'h9, 4'h0, 4'h7, 4'hE, 4'h5, 4'hC};

  ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .wr_done    (wr_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1)  we_cnt++;
    if (wr_done === 1'b1) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  initial begin
    int we0;
    int dn0;
    logic [4:0] exp_addr;
    logic [4:0] cur;
    logic got;

    reset = 1'b1;
    wr_req = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // 1: reset values, then address 0 is read without advancing
    repeat (3) cyc();
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_scan_addr", scan_addr, 0);
    check("rst_scan_data", scan_data, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_wr_done", wr_done, 0);
    reset = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      cyc();
      if (scan_valid === 1'b1) got = 1'b1;
    end
    check("first_read_valid", got, 1);
    check("first_read_addr", scan_addr, 0);
    check("first_read_data", scan_data, exp_mem[0]);
    check("first_read_idle", busy, 0);

    // 3: free-running walk through every address and back to 0
    exp_addr = 5'd0;
    for (int s = 0; s < 33; s++) begin
      cur = exp_addr;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        cyc();
        if (scan_addr !== cur) got = 1'b1;
      end
      exp_addr = exp_addr + 5'd1;
      check($sformatf("walk_step%0d_advanced", s), got, 1);
      check($sformatf("walk_step%0d_addr", s), scan_addr, exp_addr);
      check($sformatf("walk_step%0d_data", s), scan_data, exp_mem[exp_addr]);
    end

    // 2: one long wr_req pulse produces exactly one write
    do_reset();
    repeat (3) cyc();
    check("w5_scan_valid", scan_valid, 1);
    we0 = we_cnt;
    dn0 = done_cnt;
    wr_addr = 5'd5;
    wr_data = 4'hA;
    wr_req = 1'b1;
    cyc();
    check("w5_no_early_we", ram_we, 0);
    cyc();
    check("w5_we", ram_we, 1);
    check("w5_addr", ram_addr, 5);
    check("w5_din", ram_din, 4'hA);
    cyc();
    check("w5_done", wr_done, 1);
    check("w5_we_drop", ram_we, 0);
    repeat (7) cyc();
    wr_req = 1'b0;
    repeat (2) cyc();
    check("w5_we_count", we_cnt - we0, 1);
    check("w5_done_count", done_cnt - dn0, 1);
    check("w5_ram", mem[5], 4'hA);
    exp_mem[5] = 4'hA;

    // 4: write edge and tick together at scan_addr+1, write goes first
    do_reset();
    repeat (3) cyc();
    wr_addr = 5'd1;
    wr_data = 4'h6;
    wr_req = 1'b1;
    cyc();
    cyc();
    check("w1_we", ram_we, 1);
    check("w1_addr", ram_addr, 1);
    check("w1_din", ram_din, 4'h6);
    cyc();
    check("w1_done", wr_done, 1);
    cyc();
    check("w1_rd_issue_we", ram_we, 0);
    check("w1_rd_issue_addr", ram_addr, 1);
    cyc();
    cyc();
    check("w1_scan_addr", scan_addr, 1);
    check("w1_scan_data", scan_data, 4'h6);
    wr_req = 1'b0;
    exp_mem[1] = 4'h6;

    // 5: write at the shown address forces a refresh read
    do_reset();
    repeat (30) cyc();
    check("w7_pre_addr", scan_addr, 6);
    wr_addr = 5'd7;
    wr_data = 4'h3;
    wr_req = 1'b1;
    cyc();
    check("w7_at7_addr", scan_addr, 7);
    check("w7_at7_data", scan_data, exp_mem[7]);
    cyc();
    check("w7_we", ram_we, 1);
    check("w7_addr", ram_addr, 7);
    check("w7_din", ram_din, 4'h3);
    cyc();
    check("w7_done", wr_done, 1);
    cyc();
    check("w7_refresh_addr", ram_addr, 7);
    check("w7_refresh_we", ram_we, 0);
    cyc();
    cyc();
    check("w7_scan_addr", scan_addr, 7);
    check("w7_scan_data", scan_data, 4'h3);
    wr_req = 1'b0;
    exp_mem[7] = 4'h3;

    // 6a: reset during WRITE; wr_req held through reset must not write again
    do_reset();
    repeat (3) cyc();
    wr_addr = 5'd9;
    wr_data = 4'hF;
    wr_req = 1'b1;
    cyc();
    cyc();
    check("rw_we", ram_we, 1);
    reset = 1'b1;
    cyc();
    check("rw_we_low", ram_we, 0);
    check("rw_no_done", wr_done, 0);
    we0 = we_cnt;
    dn0 = done_cnt;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (6) cyc();
    check("rw_held_no_we", we_cnt - we0, 0);
    check("rw_held_no_done", done_cnt - dn0, 0);
    wr_req = 1'b0;
    exp_mem[9] = 4'hF;

    // 6b: second edge while a write is pending is dropped
    do_reset();
    repeat (4) cyc();
    we0 = we_cnt;
    dn0 = done_cnt;
    wr_addr = 5'd12;
    wr_data = 4'h5;
    wr_req = 1'b1;
    cyc();
    wr_req = 1'b0;
    cyc();
    wr_addr = 5'd13;
    wr_data = 4'h9;
    wr_req = 1'b1;
    cyc();
    cyc();
    check("de_we", ram_we, 1);
    check("de_addr", ram_addr, 12);
    check("de_din", ram_din, 4'h5);
    repeat (6) cyc();
    wr_req = 1'b0;
    repeat (2) cyc();
    check("de_we_count", we_cnt - we0, 1);
    check("de_done_count", done_cnt - dn0, 1);
    check("de_ram12", mem[12], 4'h5);
    check("de_ram13", mem[13], exp_mem[13]);
    exp_mem[12] = 4'h5;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
